fetch_queue: RTL and testbench
==============================

# fetch_queue

Instruction buffer between the fetch stage and decode. Each cycle it captures the fetch stage's PC and instruction word into a small FIFO, presents the oldest entry to decode with a valid/ready handshake, and drives the fetch stage's `stall` input when it is full. A branch redirect from decode flushes all buffered entries, so wrong-path instructions never reach decode.

## Interface
- `DEPTH`, 4: number of entries; power of two, minimum 2.
- `CW`, `$clog2(DEPTH)+1`: width of the occupancy counter.

Ports (all 32-bit buses use `[0:31]` ranges, bit 0 = MSB):
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high.
- `if_pc`  in  32  PC of the word currently being fetched.
- `if_inst`  in  32  instruction word at `if_pc`.
- `if_valid`  in  1  fetch offers `if_pc`/`if_inst` this cycle.
- `flush`  in  1  branch redirect from decode; same signal as fetch's `br_ctrl`.
- `id_ready`  in  1  decode accepts the head entry this cycle.
- `id_pc`  out  32  PC of the head entry.
- `id_inst`  out  32  instruction of the head entry.
- `id_valid`  out  1  head entry present.
- `if_stall`  out  1  drives the fetch stage's `stall`.
- `count`  out  CW  current occupancy, 0..DEPTH.

## Operation
- Storage: `DEPTH` entries, each 64 bits (`pc`, `inst`). Write pointer `wp` and read pointer `rp` are `log2(DEPTH)` bits wide and wrap modulo DEPTH. `count` is a separate register.
- `full` = (`count` == DEPTH). `empty` = (`count` == 0).
- Push = `if_valid & ~full & ~flush`: write entry[`wp`], then `wp`+1.
- Pop = `id_valid & id_ready & ~flush`: `rp`+1.
- `count` next value:
  - +1 on push only.
  - −1 on pop only.
  - Unchanged on push and pop together.
- `if_stall` = `full`, combinational from the registered `count`. It goes to 0 in the cycle after a pop frees a slot.
- When `full`, a push offered with `if_valid`=1 is not accepted. Fetch is already holding its PC because `stall`=1, so no word is lost.
- Flush is synchronous and has priority over everything else. At the next edge `wp`=`rp`=0 and `count`=0. Any push or pop in the flush cycle is discarded.
- `id_valid` = ~`empty`.
- `id_pc` and `id_inst` = entry[`rp`] when not empty, else 0x00000000.
- Decode must not depend on `id_pc`/`id_inst` while `id_valid`=0.
- `id_valid` may still be 1 in the flush cycle. Decode owns that entry, since it raised `flush` from it; it is not popped a second time.

## Timing
- Reset values: `id_valid`=0, `id_pc`=0, `id_inst`=0, `if_stall`=0, `count`=0. Pointers are 0 and storage contents are don't-care.
- Reset asserted mid-operation: the same state as power-up at the next edge, regardless of `flush`, `if_valid` or `id_ready`.
- Push-to-`id_valid` latency: 1 cycle when the queue was empty.
- Sustained throughput: 1 entry/cycle with `if_valid`=`id_ready`=1. `count` holds steady.
- Full with a pop: `count` goes DEPTH → DEPTH−1 and `if_stall` deasserts the next cycle. A push the following cycle refills the slot.
- Flush: `id_valid`=0 on the cycle after `flush`. The first redirected word can be pushed on that same cycle, and appears on `id_valid` one cycle later.
- Pointer wrap: after DEPTH pushes, `wp` returns to 0 with no bubble.

## Configuration
- `FETCH_QUEUE_BYPASS_EN` defined: when `empty`, `if_valid`=1, `id_ready`=1 and `flush`=0, the word passes straight through in the same cycle.
  - `id_valid`=1, `id_pc`=`if_pc`, `id_inst`=`if_inst`, combinationally.
  - Nothing is written and `count` stays 0. Latency is 0 cycles.
  - If `id_ready`=0, the word is pushed normally.
- Not defined: no combinational path from `if_*` to `id_*`. Latency is always at least 1 cycle.

## Test plan
- **Reset, then fill:** reset for 2 cycles, then `if_valid`=1 with PCs 0,4,8,12 and `id_ready`=0.
  - `count` steps 1..4.
  - `if_stall`=1 once `count`=4.
  - `id_pc`=0 with `id_valid`=1.
- **Drain from full:** from full, set `id_ready`=1 with `if_valid`=0.
  - `id_pc` sequence is 0,4,8,12.
  - `count` reaches 0, then `id_valid`=0 and `id_pc`=0.
  - `if_stall` drops after the first pop.
- **Streaming with wrap:** `if_valid`=`id_ready`=1 for 20 cycles, PC incrementing by 4.
  - `id_pc` lags `if_pc` by exactly 1 cycle (0 cycles with bypass).
  - `count` stays ≤1 and there are no gaps across the pointer wrap.
- **Flush with queue holding 3:** assert `flush` together with `if_valid`=1 and `if_pc`=0x100.
  - Next cycle `count`=0 and `id_valid`=0.
  - A push of 0x200 the following cycle gives `id_pc`=0x200.
- **Simultaneous push and pop when full:**
  - Push is refused and the pop is taken, so `count`=DEPTH−1.
  - Next cycle push accepted and pop taken, so `count` holds at DEPTH−1.
- **Reset mid-stream:** assert `reset` with `count`=2 and `flush`=1.
  - All outputs are 0 at the next edge.

Source files
------------

// File: rtl/fetch_queue.sv
// Instruction buffer between fetch and decode: small FIFO of {pc, inst}, stall when full, flush on redirect.
// Define FETCH_QUEUE_BYPASS_EN to pass a word straight to decode in the same cycle when the queue is empty.
module fetch_queue #(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [0:31]   if_pc,
  input  logic [0:31]   if_inst,
  input  logic          if_valid,
  input  logic          flush,
  input  logic          id_ready,
  output logic [0:31]   id_pc,
  output logic [0:31]   id_inst,
  output logic          id_valid,
  output logic          if_stall,
  output logic [CW-1:0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [0:63]   mem_q [DEPTH];
  logic [0:63]   mem_d [DEPTH];
  logic [AW-1:0] wp_q, wp_d;
  logic [AW-1:0] rp_q, rp_d;
  logic [CW-1:0] count_q, count_d;

  logic full;
  logic empty;
  logic bypass;
  logic push;
  logic pop;
  logic [0:63] head;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);

`ifdef FETCH_QUEUE_BYPASS_EN
  assign bypass = empty & if_valid & id_ready & ~flush;
`else
  assign bypass = 1'b0;
`endif

  // A bypassed word is consumed by decode directly, so it is neither written nor popped.
  assign push = if_valid & ~full & ~flush & ~bypass;
  assign pop  = ~empty & id_ready & ~flush;

  always_comb begin
    mem_d = mem_q;
    if (push) begin
      mem_d[wp_q] = {if_pc, if_inst};
    end
  end

  always_comb begin
    wp_d    = wp_q;
    rp_d    = rp_q;
    count_d = count_q;
    if (flush) begin
      wp_d    = '0;
      rp_d    = '0;
      count_d = '0;
    end else begin
      if (push) begin
        wp_d = wp_q + AW'(1);
      end
      if (pop) begin
        rp_d = rp_q + AW'(1);
      end
      if (push && !pop) begin
        count_d = count_q + CW'(1);
      end else if (pop && !push) begin
        count_d = count_q - CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wp_q    <= '0;
      rp_q    <= '0;
      count_q <= '0;
    end else begin
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      count_q <= count_d;
    end
  end

  // Storage is not reset; the output mux masks it while empty.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_comb begin
    head     = mem_q[rp_q];
    id_valid = ~empty;
    id_pc    = '0;
    id_inst  = '0;
    if (!empty) begin
      id_pc   = head[0:31];
      id_inst = head[32:63];
    end
    if (bypass) begin
      id_valid = 1'b1;
      id_pc    = if_pc;
      id_inst  = if_inst;
    end
  end

  assign if_stall = full;
  assign count    = count_q;

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed stimulus with a scoreboard of expected {pc, inst} words checked by a monitor.
module tb_fetch_queue;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

`ifdef FETCH_QUEUE_BYPASS_EN
  localparam int LAG = 0;
`else
  localparam int LAG = 1;
`endif

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;

  logic          clk = 1'b0;
  logic          reset;
  logic [0:31]   if_pc;
  logic [0:31]   if_inst;
  logic          if_valid;
  logic          flush;
  logic          id_ready;
  logic [0:31]   id_pc;
  logic [0:31]   id_inst;
  logic          id_valid;
  logic          if_stall;
  logic [CW-1:0] count;

  int   vectors    = 0;
  int   miscompares = 0;
  ent_t exp_q[$];
  ent_t mon_e;

  fetch_queue #(.DEPTH(DEPTH)) dut (
    .clk      (clk),
    .reset    (reset),
    .if_pc    (if_pc),
    .if_inst  (if_inst),
    .if_valid (if_valid),
    .flush    (flush),
    .id_ready (id_ready),
    .id_pc    (id_pc),
    .id_inst  (id_inst),
    .id_valid (id_valid),
    .if_stall (if_stall),
    .count    (count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return pc ^ 32'hA5C3_0F00;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one cycle's inputs; acc says whether the offered word is known to be accepted.
  task automatic drive(input logic v, input logic [31:0] pc, input logic rdy,
                       input logic fl, input logic acc);
    ent_t e;
    if_valid = v;
    if_pc    = pc;
    if_inst  = inst_of(pc);
    id_ready = rdy;
    flush    = fl;
    if (acc) begin
      e.pc   = pc;
      e.inst = inst_of(pc);
      exp_q.push_back(e);
    end
  endtask

  // Monitor: every transfer decode takes must match the oldest expected word.
  always @(negedge clk) begin
    if (!reset && id_valid && id_ready && !flush) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL sb_unexpected: got pc %h, required no transfer", id_pc);
      end else begin
        mon_e = exp_q.pop_front();
        if (id_pc !== mon_e.pc || id_inst !== mon_e.inst) begin
          miscompares++;
          $display("FAIL sb_data: got pc %h inst %h, required pc %h inst %h",
                   id_pc, id_inst, mon_e.pc, mon_e.inst);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, required finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    drive(0, 0, 0, 0, 0);
    tick();
    tick();
    reset = 1'b0;
    chk("rst_id_valid", 32'(id_valid), 0);
    chk("rst_id_pc",    id_pc,         0);
    chk("rst_id_inst",  id_inst,       0);
    chk("rst_if_stall", 32'(if_stall), 0);
    chk("rst_count",    32'(count),    0);

    // Fill with decode stalled.
    for (int i = 0; i < DEPTH; i++) begin
      drive(1, 32'(4 * i), 0, 0, 1);
      tick();
      chk("fill_count", 32'(count),    32'(i + 1));
      chk("fill_stall", 32'(if_stall), (i == DEPTH - 1) ? 1 : 0);
    end
    chk("fill_id_valid", 32'(id_valid), 1);
    chk("fill_id_pc",    id_pc,         0);
    drive(1, 32'd16, 0, 0, 0);
    tick();
    chk("full_refuse_count", 32'(count),    DEPTH);
    chk("full_refuse_stall", 32'(if_stall), 1);

    // Drain from full.
    drive(0, 0, 1, 0, 0);
    for (int i = 0; i < DEPTH; i++) begin
      tick();
      chk("drain_count", 32'(count), 32'(DEPTH - 1 - i));
      if (i == 0) chk("drain_stall_drop", 32'(if_stall), 0);
    end
    chk("drain_id_valid", 32'(id_valid), 0);
    chk("drain_id_pc",    id_pc,         0);
    chk("drain_id_inst",  id_inst,       0);

    // Streaming across several pointer wraps.
    for (int i = 0; i < 20; i++) begin
      drive(1, 32'h1000 + 32'(4 * i), 1, 0, 1);
      @(negedge clk);
      if (i >= LAG) begin
        chk("stream_valid", 32'(id_valid), 1);
        chk("stream_lag",   id_pc,         32'h1000 + 32'(4 * (i - LAG)));
      end
      tick();
      chk("stream_count_le1", 32'(count <= CW'(1)), 1);
    end
    drive(0, 0, 1, 0, 0);
    tick();
    chk("stream_end_count", 32'(count), 0);

    // Flush with three entries held.
    for (int i = 0; i < 3; i++) begin
      drive(1, 32'h40 + 32'(4 * i), 0, 0, 1);
      tick();
    end
    chk("preflush_count", 32'(count), 3);
    drive(1, 32'h100, 1, 1, 0);
    tick();
    exp_q.delete();
    chk("flush_count",    32'(count),    0);
    chk("flush_id_valid", 32'(id_valid), 0);
    drive(1, 32'h200, 0, 0, 1);
    tick();
    chk("redirect_id_valid", 32'(id_valid), 1);
    chk("redirect_id_pc",    id_pc,         32'h200);
    chk("redirect_count",    32'(count),    1);
    drive(0, 0, 1, 0, 0);
    tick();
    chk("redirect_drained", 32'(count), 0);

    // Simultaneous push and pop when full.
    for (int i = 0; i < DEPTH; i++) begin
      drive(1, 32'h300 + 32'(4 * i), 0, 0, 1);
      tick();
    end
    chk("pp_full_count", 32'(count), DEPTH);
    drive(1, 32'h310, 1, 0, 0);
    tick();
    chk("pp_refuse_count", 32'(count),    DEPTH - 1);
    chk("pp_refuse_stall", 32'(if_stall), 0);
    drive(1, 32'h310, 1, 0, 1);
    tick();
    chk("pp_both_count", 32'(count), DEPTH - 1);
    drive(0, 0, 1, 0, 0);
    tick();
    chk("pre_reset_count", 32'(count), 2);

    // Reset mid-stream, with flush and traffic active.
    reset = 1'b1;
    drive(1, 32'h400, 1, 1, 0);
    tick();
    exp_q.delete();
    chk("midrst_id_valid", 32'(id_valid), 0);
    chk("midrst_id_pc",    id_pc,         0);
    chk("midrst_id_inst",  id_inst,       0);
    chk("midrst_if_stall", 32'(if_stall), 0);
    chk("midrst_count",    32'(count),    0);
    reset = 1'b0;
    drive(0, 0, 0, 0, 0);
    tick();
    chk("post_rst_count", 32'(count), 0);
    chk("sb_leftover", 32'(exp_q.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
